// File: rtl/uart_trans_if.sv
// Transmit-side handshake bundle for uart_trans: baud tick, request/data in,
// done/busy/serial line out.
interface uart_trans_if #(
    parameter int DataBits = 8
);
    logic                sTick;
    logic                txStart;
    logic [DataBits-1:0] dIn;
    logic                txDoneTick;
    logic                busy;
    logic                tx;

    modport master (
        output sTick, txStart, dIn,
        input  txDoneTick, busy, tx
    );

    modport slave (
        input  sTick, txStart, dIn,
        output txDoneTick, busy, tx
    );
endinterface

// File: rtl/uart_trans.sv
// UART transmitter: one 8N1 frame per accepted request, paced by a 16x sTick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_trans #(
    parameter int DataBits = 8,
    parameter int SbTick   = 16
) (
    input logic         clk_i,
    input logic         reset_ni,
    uart_trans_if.slave txIf
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {Idle, Start, Data, Parity, Stop} state_e;
`else
    typedef enum logic [1:0] {Idle, Start, Data, Stop} state_e;
`endif

    localparam logic [4:0] BitLastTick  = 5'd15;
    localparam logic [4:0] StopLastTick = 5'(SbTick - 1);
    localparam logic [2:0] LastBit      = 3'(DataBits - 1);

    state_e              state_q, state_d;
    logic [4:0]          sReg_q, sReg_d;
    logic [2:0]          nReg_q, nReg_d;
    logic [DataBits-1:0] bReg_q, bReg_d;
    logic                txReg_q, txReg_d;
    logic                txDone;
`ifdef UART_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= Idle;
            sReg_q   <= '0;
            nReg_q   <= '0;
            bReg_q   <= '0;
            txReg_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sReg_q   <= sReg_d;
            nReg_q   <= nReg_d;
            bReg_q   <= bReg_d;
            txReg_q  <= txReg_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // The line value is computed from the current state and registered, so tx
    // trails the state by exactly one clock and is glitch-free at the pin.
    always_comb begin
        state_d  = state_q;
        sReg_d   = sReg_q;
        nReg_d   = nReg_q;
        bReg_d   = bReg_q;
        txReg_d  = 1'b1;
        txDone   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            Idle: begin
                txReg_d = 1'b1;
                if (txIf.txStart) begin
                    bReg_d  = txIf.dIn;
                    sReg_d  = '0;
                    state_d = Start;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^txIf.dIn;
`endif
                end
            end
            Start: begin
                txReg_d = 1'b0;
                if (txIf.sTick) begin
                    if (sReg_q == BitLastTick) begin
                        sReg_d  = '0;
                        nReg_d  = '0;
                        state_d = Data;
                    end else begin
                        sReg_d = sReg_q + 5'd1;
                    end
                end
            end
            Data: begin
                txReg_d = bReg_q[0];
                if (txIf.sTick) begin
                    if (sReg_q == BitLastTick) begin
                        sReg_d = '0;
                        bReg_d = bReg_q >> 1;
                        if (nReg_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
                            state_d = Parity;
`else
                            state_d = Stop;
`endif
                        end else begin
                            nReg_d = nReg_q + 3'd1;
                        end
                    end else begin
                        sReg_d = sReg_q + 5'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            Parity: begin
                txReg_d = parity_q;
                if (txIf.sTick) begin
                    if (sReg_q == BitLastTick) begin
                        sReg_d  = '0;
                        state_d = Stop;
                    end else begin
                        sReg_d = sReg_q + 5'd1;
                    end
                end
            end
`endif
            Stop: begin
                txReg_d = 1'b1;
                if (txIf.sTick) begin
                    if (sReg_q == StopLastTick) begin
                        txDone  = 1'b1;
                        state_d = Idle;
                    end else begin
                        sReg_d = sReg_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = Idle;
            end
        endcase
    end

    assign txIf.txDoneTick = txDone;
    assign txIf.busy       = (state_q != Idle);
    assign txIf.tx         = txReg_q;

endmodule

// File: tb/tb_uart_trans.sv
// Directed self-checking bench for uart_trans: reset, single frame, ignored
// request, back-to-back frames, mid-frame reset and (with the macro) parity.
module tb_uart_trans;

    logic clk;
    logic reset_n;
    int   checks    = 0;
    int   errors    = 0;
    int   doneCount = 0;

    uart_trans_if #(.DataBits(8)) txIf();

    uart_trans #(.DataBits(8), .SbTick(16)) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .txIf     (txIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sTick: one clock high out of every four, changed just after the rising edge.
    initial begin
        int div;
        div = 0;
        txIf.sTick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div = (div + 1) % 4;
            txIf.sTick = (div == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (txIf.txDoneTick === 1'b1) doneCount++;
        end
    end

    task automatic sendPulse(input logic [7:0] d);
        @(posedge clk);
        #1;
        txIf.dIn = d;
        txIf.txStart = 1'b1;
        @(posedge clk);
        #1;
        txIf.txStart = 1'b0;
    endtask

    task automatic waitFall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (txIf.tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitDone(output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (txIf.txDoneTick === 1'b1) begin
                ok = 1'b1;
                cycles = i;
                break;
            end
        end
    endtask

    // Starts at the negedge where the start bit was first seen; samples mid-bit.
    task automatic sampleBits(output logic [7:0] data, output logic startBit,
                              output logic parityBit, output logic stopBit);
        repeat (32) @(negedge clk);
        startBit = txIf.tx;
        for (int i = 0; i < 8; i++) begin
            repeat (64) @(negedge clk);
            data[i] = txIf.tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (64) @(negedge clk);
        parityBit = txIf.tx;
`else
        parityBit = 1'b0;
`endif
        repeat (64) @(negedge clk);
        stopBit = txIf.tx;
    endtask

    task automatic test_reset();
        int highCount;
        reset_n = 1'b0;
        txIf.txStart = 1'b0;
        txIf.dIn = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (txIf.tx !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_tx: got %b expected 1", txIf.tx);
        end
        checks++;
        if (txIf.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_busy: got %b expected 0", txIf.busy);
        end
        checks++;
        if (txIf.txDoneTick !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_done: got %b expected 0", txIf.txDoneTick);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        highCount = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txIf.tx === 1'b1 && txIf.busy === 1'b0) highCount++;
        end
        checks++;
        if (highCount !== 100) begin
            errors++; $display("[TB] FAIL idle_line: got %0d idle cycles expected 100", highCount);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] d;
        logic       s, p, st;
        bit         ok;
        int         cyc, db, frameLen;
        db = doneCount;
        @(posedge clk);
        #1;
        txIf.dIn = 8'h55;
        txIf.txStart = 1'b1;
        @(negedge clk);
        checks++;
        if (txIf.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL busy_before_accept: got %b expected 0", txIf.busy);
        end
        @(posedge clk);
        #1;
        txIf.txStart = 1'b0;
        @(negedge clk);
        checks++;
        if (txIf.busy !== 1'b1 || txIf.tx !== 1'b1) begin
            errors++; $display("[TB] FAIL accept_edge: got busy=%b tx=%b expected busy=1 tx=1", txIf.busy, txIf.tx);
        end
        @(negedge clk);
        checks++;
        if (txIf.tx !== 1'b0) begin
            errors++; $display("[TB] FAIL start_fall: got tx=%b expected 0", txIf.tx);
        end
        sampleBits(d, s, p, st);
        checks++;
        if ({st, d, s} !== 10'b1_0101_0101_0) begin
            errors++; $display("[TB] FAIL frame_55: got %b expected 1010101010", {st, d, s});
        end
        waitDone(ok, cyc);
        frameLen = 32 + 8 * 64 + 64 + cyc;
        checks++;
        if (!ok || frameLen < 634 || frameLen > 639) begin
            errors++; $display("[TB] FAIL frame_len: got ok=%0d len=%0d expected 634..639 clk", ok, frameLen);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (doneCount - db !== 1 || txIf.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL single_done: got %0d pulses busy=%b expected 1 pulse busy=0", doneCount - db, txIf.busy);
        end
    endtask

    task automatic test_ignored_request();
        logic [7:0] d;
        logic       s, p, st;
        bit         ok;
        int         cyc, db, badIdle;
        db = doneCount;
        sendPulse(8'hA3);
        waitFall(ok);
        checks++;
        if (!ok) begin
            errors++; $display("[TB] FAIL ignored_fall: got no start bit expected one");
        end
        fork
            sampleBits(d, s, p, st);
            begin
                repeat (200) @(posedge clk);
                #1;
                txIf.dIn = 8'hFF;
                txIf.txStart = 1'b1;
                @(posedge clk);
                #1;
                txIf.txStart = 1'b0;
            end
        join
        checks++;
        if (d !== 8'hA3 || s !== 1'b0 || st !== 1'b1) begin
            errors++; $display("[TB] FAIL ignored_frame: got data=%h start=%b stop=%b expected A3 0 1", d, s, st);
        end
        waitDone(ok, cyc);
        badIdle = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (txIf.tx !== 1'b1 || txIf.busy !== 1'b0) badIdle++;
        end
        checks++;
        if (!ok || doneCount - db !== 1 || badIdle !== 0) begin
            errors++; $display("[TB] FAIL ignored_single: got ok=%0d pulses=%0d nonidle=%0d expected 1 1 0", ok, doneCount - db, badIdle);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic       s, p, st;
        bit         ok;
        int         cyc, db, gap, busyLow;
        db = doneCount;
        @(posedge clk);
        #1;
        txIf.dIn = 8'h0F;
        txIf.txStart = 1'b1;
        waitFall(ok);
        sampleBits(d, s, p, st);
        checks++;
        if (!ok || d !== 8'h0F || st !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_first: got ok=%0d data=%h stop=%b expected 1 0F 1", ok, d, st);
        end
        waitDone(ok, cyc);
        gap = 0;
        busyLow = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) txIf.dIn = 8'hF0;
            @(negedge clk);
            if (txIf.busy === 1'b0) busyLow++;
            if (txIf.tx === 1'b0) begin
                gap = i;
                break;
            end
        end
        checks++;
        if (!ok || gap !== 3 || busyLow !== 1) begin
            errors++; $display("[TB] FAIL b2b_gap: got fall after %0d clk idle=%0d expected 3 and 1", gap, busyLow);
        end
        @(posedge clk);
        #1;
        txIf.txStart = 1'b0;
        sampleBits(d, s, p, st);
        checks++;
        if (d !== 8'hF0 || s !== 1'b0 || st !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_second: got data=%h start=%b stop=%b expected F0 0 1", d, s, st);
        end
        waitDone(ok, cyc);
        repeat (4) @(negedge clk);
        checks++;
        if (!ok || doneCount - db !== 2 || txIf.busy !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_done: got pulses=%0d busy=%b expected 2 and 0", doneCount - db, txIf.busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        logic       s, p, st;
        bit         ok;
        int         cyc, db;
        db = doneCount;
        sendPulse(8'h35);
        waitFall(ok);
        repeat (32 + 4 * 64) @(negedge clk);
        checks++;
        if (!ok || txIf.tx !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_bit3: got ok=%0d tx=%b expected 1 0", ok, txIf.tx);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (txIf.tx !== 1'b1 || txIf.busy !== 1'b0 || txIf.txDoneTick !== 1'b0) begin
            errors++; $display("[TB] FAIL async_reset: got tx=%b busy=%b done=%b expected 1 0 0", txIf.tx, txIf.busy, txIf.txDoneTick);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (doneCount !== db || txIf.tx !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_no_done: got pulses=%0d tx=%b expected 0 1", doneCount - db, txIf.tx);
        end
        sendPulse(8'h96);
        waitFall(ok);
        sampleBits(d, s, p, st);
        checks++;
        if (!ok || d !== 8'h96 || s !== 1'b0 || st !== 1'b1) begin
            errors++; $display("[TB] FAIL after_reset_frame: got data=%h start=%b stop=%b expected 96 0 1", d, s, st);
        end
        waitDone(ok, cyc);
        checks++;
        if (!ok || doneCount - db !== 1) begin
            errors++; $display("[TB] FAIL after_reset_done: got pulses=%0d expected 1", doneCount - db);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d;
        logic       s, p, st;
        bit         ok;
        int         cyc, frameLen;
        sendPulse(8'h07);
        waitFall(ok);
        sampleBits(d, s, p, st);
        checks++;
        if (!ok || d !== 8'h07 || p !== 1'b1 || st !== 1'b1) begin
            errors++; $display("[TB] FAIL parity_07: got data=%h parity=%b stop=%b expected 07 1 1", d, p, st);
        end
        waitDone(ok, cyc);
        frameLen = 32 + 9 * 64 + 64 + cyc;
        checks++;
        if (!ok || frameLen < 698 || frameLen > 703) begin
            errors++; $display("[TB] FAIL parity_len: got len=%0d expected 698..703 clk", frameLen);
        end
        sendPulse(8'h03);
        waitFall(ok);
        sampleBits(d, s, p, st);
        checks++;
        if (!ok || d !== 8'h03 || p !== 1'b0) begin
            errors++; $display("[TB] FAIL parity_03: got data=%h parity=%b expected 03 0", d, p);
        end
        waitDone(ok, cyc);
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_ignored_request();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
